// File: rtl/wb_pkg.sv
// Bus-wide constants shared by every block that talks on the Wishbone bus.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_SEL_W  = 4;
endpackage

// File: rtl/wb_bus_t.sv
// Wishbone classic bus bundle; tag/lock/grant lines travel with the bus but
// a plain RAM slave has no use for them.
interface wb_bus_t;
  import wb_pkg::*;
  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic [WB_SEL_W-1:0]  wb_sel;
  logic [WB_ADDR_W-1:0] wb_adr;
  logic [WB_DATA_W-1:0] wb_dat_ms;
  logic [WB_DATA_W-1:0] wb_dat_sm;
  logic                 wb_ack;
  logic                 wb_gnt;
  logic                 wb_lock;
  logic                 wb_tgc;
  logic                 wb_tga;
  logic                 wb_tgd_ms;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
           wb_gnt, wb_lock, wb_tgc, wb_tga, wb_tgd_ms,
    input  wb_dat_sm, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_ms,
           wb_gnt, wb_lock, wb_tgc, wb_tga, wb_tgd_ms,
    output wb_dat_sm, wb_ack
  );
endinterface

// File: rtl/sram_1rw_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module sram_1rw_be
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [WB_SEL_W-1:0]  be,
  input  logic [AW-1:0]        addr,
  input  logic [WB_DATA_W-1:0] wdata,
  output logic [WB_DATA_W-1:0] rdata
);
  logic [WB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int n = 0; n < WB_SEL_W; n++) begin
          if (be[n]) mem[addr][8*n +: 8] <= wdata[8*n +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave: one access at a time, optional wait states,
// out-of-range accesses acked with err_o instead of touching the RAM.
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                   DEPTH       = 1024,
  parameter int                   WAIT_STATES = 0
) (
  input  logic   clk,
  input  logic   rst_i,
  wb_bus_t.slave wb_bus,
  output logic   err_o
);
  localparam int AW      = $clog2(DEPTH);
  localparam int WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  typedef logic [WB_ADDR_W:0] adr_ext_t;
  localparam adr_ext_t SPAN = adr_ext_t'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t               state, state_nx;
  logic [3:0]           wait_cnt, wait_cnt_nx;
  logic                 accept, go_ack;
  logic [WB_ADDR_W-1:0] adr_p0, cur_adr;
  logic [WB_SEL_W-1:0]  sel_p0, cur_sel;
  logic [WB_DATA_W-1:0] dat_p0, cur_dat;
  logic                 we_p0, cur_we;
  adr_ext_t             adr_diff;
  logic                 in_range;
  logic [AW-1:0]        word_idx;
  logic [WB_DATA_W-1:0] ram_q, rd_word, dat_sm_q;
  logic                 unused_tags;

  assign unused_tags = ^{wb_bus.wb_gnt, wb_bus.wb_lock, wb_bus.wb_tgc,
                         wb_bus.wb_tga, wb_bus.wb_tgd_ms};

  // With no wait states the RAM is hit on the accept edge itself, so the
  // live bus is used in IDLE and the latched request everywhere else.
  assign cur_adr = (state == IDLE) ? wb_bus.wb_adr    : adr_p0;
  assign cur_we  = (state == IDLE) ? wb_bus.wb_we     : we_p0;
  assign cur_sel = (state == IDLE) ? wb_bus.wb_sel    : sel_p0;
  assign cur_dat = (state == IDLE) ? wb_bus.wb_dat_ms : dat_p0;

  // A borrow below BASE_ADDR lands in the top bit and fails the span test.
  assign adr_diff = adr_ext_t'(cur_adr) - adr_ext_t'(BASE_ADDR);
  assign in_range = adr_diff < SPAN;
  assign word_idx = AW'(adr_diff >> 2);

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    accept      = 1'b0;
    go_ack      = 1'b0;
    unique case (state)
      IDLE: begin
        if (wb_bus.wb_cyc && wb_bus.wb_stb) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = ACK;
            go_ack   = 1'b1;
          end else begin
            state_nx    = WAIT;
            wait_cnt_nx = 4'(WS_LOAD);
          end
        end
      end
      WAIT: begin
        if (!(wb_bus.wb_cyc && wb_bus.wb_stb)) begin
          state_nx = IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_nx = ACK;
          go_ack   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  sram_1rw_be #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (go_ack && in_range && !rst_i),
    .we    (cur_we),
    .be    (cur_sel),
    .addr  (word_idx),
    .wdata (cur_dat),
    .rdata (ram_q)
  );

  // The RAM read lands during ACK; the holding register takes over afterwards.
  assign rd_word          = err_o ? '0 : ram_q;
  assign wb_bus.wb_dat_sm = (state == ACK && !we_p0) ? rd_word : dat_sm_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      wb_bus.wb_ack <= 1'b0;
      err_o         <= 1'b0;
      dat_sm_q      <= '0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= wait_cnt_nx;
      wb_bus.wb_ack <= go_ack;
      err_o         <= go_ack && !in_range;
      if (state == ACK && !we_p0) dat_sm_q <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      adr_p0 <= wb_bus.wb_adr;
      we_p0  <= wb_bus.wb_we;
      sel_p0 <= wb_bus.wb_sel;
      dat_p0 <= wb_bus.wb_dat_ms;
    end
  end
endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: a zero-wait and a three-wait instance share one
// stimulus bus and are checked against an array model of memory contents.
module tb_wb_ram_slave;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cyc;
  logic        stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        gnt, lock, tgc, tga, tgd;
  logic        err0, err1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  wb_bus_t bus0();
  wb_bus_t bus1();

  assign bus0.wb_cyc = cyc[0];  assign bus1.wb_cyc = cyc[1];
  assign bus0.wb_stb = stb;     assign bus1.wb_stb = stb;
  assign bus0.wb_we  = we;      assign bus1.wb_we  = we;
  assign bus0.wb_sel = sel;     assign bus1.wb_sel = sel;
  assign bus0.wb_adr = adr;     assign bus1.wb_adr = adr;
  assign bus0.wb_dat_ms = dat;  assign bus1.wb_dat_ms = dat;
  assign bus0.wb_gnt = gnt;     assign bus1.wb_gnt = gnt;
  assign bus0.wb_lock = lock;   assign bus1.wb_lock = lock;
  assign bus0.wb_tgc = tgc;     assign bus1.wb_tgc = tgc;
  assign bus0.wb_tga = tga;     assign bus1.wb_tga = tga;
  assign bus0.wb_tgd_ms = tgd;  assign bus1.wb_tgd_ms = tgd;

  wb_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_i(rst), .wb_bus(bus0), .err_o(err0));
  wb_ram_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_i(rst), .wb_bus(bus1), .err_o(err1));

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction
  function automatic logic ack_of(input int i);
    return (i == 0) ? bus0.wb_ack : bus1.wb_ack;
  endfunction
  function automatic logic err_of(input int i);
    return (i == 0) ? err0 : err1;
  endfunction
  function automatic logic [31:0] dat_of(input int i);
    return (i == 0) ? bus0.wb_dat_sm : bus1.wb_dat_sm;
  endfunction

  // Reference model: plain address arithmetic over a word array.
  function automatic logic in_rng(input logic [31:0] a);
    longint la;
    la = a;
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction
  function automatic logic [31:0] mdl_read(input int i, input logic [31:0] a);
    return in_rng(a) ? mdl[i][widx(a)] : 32'h0;
  endfunction
  task automatic mdl_write(input int i, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d);
    if (in_rng(a))
      for (int n = 0; n < 4; n++)
        if (s[n]) mdl[i][widx(a)][8*n +: 8] = d[8*n +: 8];
  endtask
  function automatic logic [31:0] rand_addr();
    int m;
    m = $urandom_range(0, 9);
    if (m == 0) return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
    if (m == 1) return BASE - 32'($urandom_range(1, 64));
    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
  endfunction

  // One complete bus access; returns the ack cycle (0 on timeout) and the
  // outputs seen in the ack cycle and in the cycle after it.
  task automatic do_access(input int i, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic e,
                           output logic ack_n, output logic err_n, output logic [31:0] dat_n);
    adr = a; we = w; sel = s; dat = d; stb = 1'b1; cyc[i] = 1'b1;
    lat = 0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (ack_of(i)) begin lat = k; rd = dat_of(i); e = err_of(i); break; end
    end
    cyc = 2'b00; stb = 1'b0;
    adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
    {gnt, lock, tgc, tga, tgd} = 5'($urandom);
    @(posedge clk); #1;
    ack_n = ack_of(i); err_n = err_of(i); dat_n = dat_of(i);
  endtask

  task automatic test_reset;
    cyc = 2'b00; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
    {gnt, lock, tgc, tga, tgd} = 5'b10101;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ack_of(i) !== 1'b0) begin errors++; $display("FAIL reset_ack inst%0d: got %b want 0", i, ack_of(i)); end
      checks++; if (err_of(i) !== 1'b0) begin errors++; $display("FAIL reset_err inst%0d: got %b want 0", i, err_of(i)); end
      checks++; if (dat_of(i) !== 32'h0) begin errors++; $display("FAIL reset_dat inst%0d: got %h want 0", i, dat_of(i)); end
      last_rd[i] = 32'h0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int lat; logic [31:0] rd, dn; logic e, an, en;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        logic [31:0] d;
        d = $urandom;
        do_access(i, 1'b1, BASE + 32'(4 * j), 4'hF, d, lat, rd, e, an, en, dn);
        mdl_write(i, BASE + 32'(4 * j), 4'hF, d);
        checks++;
        if (lat != ws_of(i) + 1 || e !== 1'b0) begin
          errors++; $display("FAIL fill inst%0d word%0d: latency %0d err %b, want latency %0d err 0", i, j, lat, e, ws_of(i) + 1);
        end
      end
    end
  endtask

  task automatic test_basic;
    int lat; logic [31:0] rd, dn; logic e, an, en;
    do_access(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, e, an, en, dn);
    mdl_write(0, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
    checks++; if (lat != 1) begin errors++; $display("FAIL basic_wr_latency: got %0d want 1", lat); end
    checks++; if (an !== 1'b0) begin errors++; $display("FAIL basic_ack_one_cycle: got %b want 0", an); end
    do_access(0, 1'b0, BASE + 32'h10, 4'h0, 32'h0, lat, rd, e, an, en, dn);
    last_rd[0] = 32'hDEADBEEF;
    checks++; if (lat != 1) begin errors++; $display("FAIL basic_rd_latency: got %0d want 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
    checks++; if (dn !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_hold: got %h want deadbeef", dn); end
  endtask

  task automatic test_byte_lanes;
    int lat; logic [31:0] rd, dn; logic e, an, en;
    logic [31:0] a;
    a = BASE + 32'h20;
    do_access(0, 1'b1, a, 4'hF, 32'hDEADBEEF, lat, rd, e, an, en, dn);
    do_access(0, 1'b1, a, 4'b0101, 32'h11223344, lat, rd, e, an, en, dn);
    mdl_write(0, a, 4'hF, 32'hDEADBEEF);
    mdl_write(0, a, 4'b0101, 32'h11223344);
    do_access(0, 1'b0, a, 4'h0, 32'h0, lat, rd, e, an, en, dn);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL lanes_0101: got %h want de22be44", rd); end
    do_access(0, 1'b1, a, 4'b0000, 32'hFFFFFFFF, lat, rd, e, an, en, dn);
    checks++; if (lat != 1 || e !== 1'b0) begin errors++; $display("FAIL lanes_sel0_ack: latency %0d err %b want 1/0", lat, e); end
    do_access(0, 1'b0, a, 4'hF, 32'h0, lat, rd, e, an, en, dn);
    last_rd[0] = 32'hDE22BE44;
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL lanes_sel0_nochange: got %h want de22be44", rd); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      int j, per;
      logic [31:0] a, d;
      j = $urandom_range(0, DEPTH - 1);
      a = BASE + 32'(4 * j);
      d = mdl_read(i, a);
      per = ws_of(i) + 2;
      adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc[i] = 1'b1;
      for (int k = 0; k <= 2 * per + 1; k++) begin
        logic exp_ack;
        @(posedge clk); #1;
        exp_ack = (k % per) == ws_of(i);
        checks++;
        if (ack_of(i) !== exp_ack) begin
          errors++; $display("FAIL b2b_ack inst%0d cycle%0d: got %b want %b", i, k + 1, ack_of(i), exp_ack);
        end
        if (exp_ack) begin
          checks++; if (dat_of(i) !== d) begin errors++; $display("FAIL b2b_data inst%0d: got %h want %h", i, dat_of(i), d); end
        end
      end
      cyc = 2'b00; stb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      last_rd[i] = d;
      checks++; if (dat_of(i) !== d) begin errors++; $display("FAIL b2b_hold inst%0d: got %h want %h", i, dat_of(i), d); end
    end
  endtask

  task automatic test_abort;
    int lat, j; logic [31:0] rd, dn, a, old; logic e, an, en;
    j = $urandom_range(0, DEPTH - 1);
    a = BASE + 32'(4 * j);
    old = mdl[1][j];
    adr = a; we = 1'b1; sel = 4'hF; dat = ~old; stb = 1'b1; cyc[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) stb = 1'b0;
      checks++; if (ack_of(1) !== 1'b0) begin errors++; $display("FAIL abort_no_ack cycle%0d: got %b want 0", k + 1, ack_of(1)); end
      checks++; if (dat_of(1) !== last_rd[1]) begin errors++; $display("FAIL abort_dat_kept cycle%0d: got %h want %h", k + 1, dat_of(1), last_rd[1]); end
    end
    cyc = 2'b00;
    do_access(1, 1'b0, a, 4'hF, 32'h0, lat, rd, e, an, en, dn);
    last_rd[1] = old;
    checks++; if (rd !== old) begin errors++; $display("FAIL abort_no_write: got %h want %h", rd, old); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd, dn, a; logic e, an, en;
    a = BASE + 32'(4 * DEPTH);
    for (int i = 0; i < 2; i++) begin
      do_access(i, 1'b0, a, 4'hF, 32'h0, lat, rd, e, an, en, dn);
      last_rd[i] = 32'h0;
      checks++; if (lat != ws_of(i) + 1) begin errors++; $display("FAIL oor_rd_ack inst%0d: latency %0d want %0d", i, lat, ws_of(i) + 1); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err inst%0d: got %b want 1", i, e); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data inst%0d: got %h want 0", i, rd); end
      checks++; if (en !== 1'b0 || dn !== 32'h0) begin errors++; $display("FAIL oor_after inst%0d: err %b dat %h want 0/0", i, en, dn); end
      do_access(i, 1'b1, a, 4'hF, 32'hA5A5A5A5, lat, rd, e, an, en, dn);
      checks++; if (e !== 1'b1 || lat != ws_of(i) + 1) begin errors++; $display("FAIL oor_wr inst%0d: err %b latency %0d want 1/%0d", i, e, lat, ws_of(i) + 1); end
      do_access(i, 1'b1, BASE - 32'd4, 4'hF, 32'h5A5A5A5A, lat, rd, e, an, en, dn);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL below_base_wr inst%0d: err %b want 1", i, e); end
    end
  endtask

  task automatic test_reset_mid;
    int lat, j, re; logic [31:0] rd, dn, a, old; logic e, an, en;
    for (int v = 0; v < 2; v++) begin
      re = (v == 0) ? 1 : 3;
      j = $urandom_range(0, DEPTH - 1);
      a = BASE + 32'(4 * j);
      old = mdl[1][j];
      adr = a; we = 1'b1; sel = 4'hF; dat = ~old; stb = 1'b1; cyc[1] = 1'b1;
      for (int k = 0; k < re; k++) begin
        @(posedge clk); #1;
        checks++; if (ack_of(1) !== 1'b0) begin errors++; $display("FAIL rstmid_wait_ack edge%0d: got %b want 0", k, ack_of(1)); end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cyc = 2'b00; stb = 1'b0;
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
      checks++; if (ack_of(1) !== 1'b0 || err_of(1) !== 1'b0 || dat_of(1) !== 32'h0) begin
        errors++; $display("FAIL rstmid_outputs edge%0d: ack %b err %b dat %h want 0/0/0", re, ack_of(1), err_of(1), dat_of(1));
      end
      do_access(1, 1'b0, a, 4'hF, 32'h0, lat, rd, e, an, en, dn);
      last_rd[1] = old;
      checks++; if (lat != 4) begin errors++; $display("FAIL rstmid_idle_latency edge%0d: got %0d want 4", re, lat); end
      checks++; if (rd !== old) begin errors++; $display("FAIL rstmid_no_write edge%0d: got %h want %h", re, rd, old); end
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd, dn; logic e, an, en;
    for (int n = 0; n < 150; n++) begin
      int i;
      logic w;
      logic [3:0] s;
      logic [31:0] a, d, exp_rd;
      i = $urandom_range(0, 1);
      w = 1'($urandom);
      s = 4'($urandom);
      a = rand_addr();
      d = $urandom;
      exp_rd = mdl_read(i, a);
      do_access(i, w, a, s, d, lat, rd, e, an, en, dn);
      if (w) mdl_write(i, a, s, d);
      else last_rd[i] = exp_rd;
      checks++;
      if (lat != ws_of(i) + 1 || e !== !in_rng(a)) begin
        errors++; $display("FAIL rand_ack n%0d inst%0d adr %h: latency %0d err %b want %0d/%b", n, i, a, lat, e, ws_of(i) + 1, !in_rng(a));
      end
      if (!w) begin
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rd n%0d inst%0d adr %h: got %h want %h", n, i, a, rd, exp_rd); end
      end
      checks++;
      if (an !== 1'b0 || en !== 1'b0 || dn !== last_rd[i]) begin
        errors++; $display("FAIL rand_after n%0d inst%0d: ack %b err %b dat %h want 0/0/%h", n, i, an, en, dn, last_rd[i]);
      end
    end
  endtask

  task automatic test_scan;
    int lat; logic [31:0] rd, dn; logic e, an, en;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        do_access(i, 1'b0, BASE + 32'(4 * j), 4'h0, 32'h0, lat, rd, e, an, en, dn);
        last_rd[i] = mdl[i][j];
        checks++;
        if (rd !== mdl[i][j]) begin errors++; $display("FAIL scan inst%0d word%0d: got %h want %h", i, j, rd, mdl[i][j]); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_byte_lanes();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    test_reset_mid();
    test_random();
    test_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
